// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage that streams ROM words through a prefetch FIFO to decode
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_en_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [31:0] pc;
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic has, push, pop;
    assign has          = count != '0;
    assign inst_valid_o = has && !jump_en_i;
    assign pop          = inst_valid_o && inst_ready_i;
    // a pop frees the head slot in time for this cycle's write, so push is legal when full
    assign push         = rst && !jump_en_i && (count < FULL || pop);
    assign rom_en_o     = push;
    assign rom_addr_o   = pc & 32'hFFFF_FFFC;
    assign inst_o       = has ? mem_inst[rd_ptr] : '0;
    assign inst_addr_o  = has ? mem_addr[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= rom_addr_o;
            mem_inst[wr_ptr] <= rom_data_i;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jump_en_i) begin
            pc     <= jump_addr_i & 32'hFFFF_FFFC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= rom_addr_o + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized scoreboard bench for if_fetch against a contiguous-stream reference model
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst, rom_en_o, jump_en_i, inst_valid_o, inst_ready_i;
    logic [31:0] rom_addr_o, rom_data_i, jump_addr_i, inst_o, inst_addr_o;
    int pass_cnt = 0, total_cnt = 0, acc = 0;
    logic [31:0] q[$];
    logic [31:0] nxt = RESET_PC;
    always #5 clk = ~clk;
    // ROM[i] = i, word indexed
    assign rom_data_i = {2'b00, rom_addr_o[31:2]};
    if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total_cnt++;
        if (a !== e) $display("FAIL %s: got %h, expected %h", n, a, e);
        else pass_cnt++;
    endtask
    // accepted stream is contiguous from the latest redirect target; one expected entry queued per cycle
    task automatic model();
        if (!rst) begin
            q.delete();
            nxt = RESET_PC & 32'hFFFF_FFFC;
        end else if (jump_en_i) begin
            q.delete();
            nxt = jump_addr_i & 32'hFFFF_FFFC;
        end
        q.push_back(nxt);
        nxt = nxt + 32'd4;
    endtask
    task automatic pre();
        model();
        @(negedge clk);
    endtask
    task automatic post();
        @(posedge clk);
        #1;
    endtask
    task automatic step(input int n);
        repeat (n) begin
            pre();
            post();
        end
    endtask
    initial begin
        int a0, pushes;
        rst = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0; inst_ready_i = 1'b0;
        fork
            forever begin
                logic [31:0] e;
                @(negedge clk);
                if (rst === 1'b1 && jump_en_i) chk("jump_hides_valid", 32'(inst_valid_o), 32'd0);
                if (rst === 1'b1 && inst_valid_o === 1'b1 && inst_ready_i) begin
                    if (q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL sb_empty: accepted addr %h, expected no entry", inst_addr_o);
                    end else begin
                        e = q.pop_front();
                        chk("sb_addr", inst_addr_o, e);
                        chk("sb_inst", inst_o, e >> 2);
                    end
                    acc++;
                end
            end
        join_none
        step(3);
        pre();
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_addr", inst_addr_o, 32'd0);
        chk("rst_rom_en", 32'(rom_en_o), 32'd0);
        post();
        rst = 1'b1; inst_ready_i = 1'b1; a0 = acc;
        pre();
        chk("start_rom_en", 32'(rom_en_o), 32'd1);
        chk("start_rom_addr", rom_addr_o, RESET_PC);
        chk("start_valid", 32'(inst_valid_o), 32'd0);
        post();
        pre();
        chk("start_valid2", 32'(inst_valid_o), 32'd1);
        chk("start_inst_addr", inst_addr_o, RESET_PC);
        post();
        step(8);
        chk("stream_accepts", 32'(acc - a0), 32'd9);
        rst = 1'b0; inst_ready_i = 1'b0;
        step(3);
        rst = 1'b1; pushes = 0;
        repeat (10) begin
            pre();
            if (rom_en_o) pushes++;
            post();
        end
        chk("bp_pushes", 32'(pushes), 32'(DEPTH));
        pre();
        chk("bp_rom_en", 32'(rom_en_o), 32'd0);
        chk("bp_pc", rom_addr_o, 32'(4 * DEPTH));
        chk("bp_valid", 32'(inst_valid_o), 32'd1);
        post();
        inst_ready_i = 1'b1; a0 = acc;
        pre();
        chk("full_pop_push", 32'(rom_en_o), 32'd1);
        post();
        step(DEPTH + 3);
        chk("full_accepts", 32'(acc - a0), 32'(DEPTH + 4));
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0067;
        pre();
        chk("jmp_valid", 32'(inst_valid_o), 32'd0);
        chk("jmp_rom_en", 32'(rom_en_o), 32'd0);
        post();
        jump_en_i = 1'b0;
        pre();
        chk("jmp_rom_addr", rom_addr_o, 32'h64);
        post();
        pre();
        chk("jmp_head", inst_addr_o, 32'h64);
        post();
        step(3);
        jump_en_i = 1'b1; jump_addr_i = 32'h100;
        step(1);
        jump_addr_i = 32'h200;
        step(1);
        jump_en_i = 1'b0;
        pre();
        chk("jj_rom_addr", rom_addr_o, 32'h200);
        post();
        step(3);
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8;
        step(1);
        jump_en_i = 1'b0; a0 = acc;
        step(6);
        chk("wrap_accepts", 32'(acc - a0), 32'd5);
        inst_ready_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h40;
        step(1);
        jump_en_i = 1'b0;
        step(2);
        pre();
        chk("half_valid", 32'(inst_valid_o), 32'd1);
        post();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        pre();
        chk("mid_rst_valid", 32'(inst_valid_o), 32'd0);
        chk("mid_rst_addr", rom_addr_o, RESET_PC);
        post();
        inst_ready_i = 1'b1;
        pre();
        chk("mid_rst_head", inst_addr_o, RESET_PC);
        post();
        repeat (1500) begin
            inst_ready_i = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 63) != 0;
            jump_en_i = rst && $urandom_range(0, 15) == 0;
            jump_addr_i = $urandom;
            step(1);
        end
        rst = 1'b1; jump_en_i = 1'b0; inst_ready_i = 1'b1;
        step(4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the prefetch FIFO entry count; legal values are 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port rom_en_o, output, 1 bit: instruction ROM read enable.
REQ-006 SHALL have port rom_addr_o, output, 32 bits: ROM byte address; the ROM indexes by addr[31:2].
REQ-007 SHALL have port rom_data_i, input, 32 bits: ROM read data, combinationally valid in the same cycle as rom_addr_o.
REQ-008 SHALL have port jump_en_i, input, 1 bit: redirect request from execute.
REQ-009 SHALL have port jump_addr_i, input, 32 bits: redirect target.
REQ-010 SHALL have port inst_valid_o, output, 1 bit: the FIFO head holds a valid instruction.
REQ-011 SHALL have port inst_ready_i, input, 1 bit: decode accepts the head.
REQ-012 SHALL have port inst_o, output, 32 bits: the head instruction word.
REQ-013 SHALL have port inst_addr_o, output, 32 bits: the head instruction address.

Function
REQ-014 SHALL hold a 32-bit fetch PC register pc, a DEPTH-entry FIFO of {addr, inst} pairs, read and write pointers of log2(DEPTH) bits, and an occupancy count of log2(DEPTH)+1 bits.
REQ-015 SHALL drive rom_addr_o = pc at all times, with bits [1:0] always 2'b00.
REQ-016 SHALL define pop = inst_valid_o && inst_ready_i && !jump_en_i.
REQ-017 SHALL define push = rst && !jump_en_i && (count < DEPTH || pop).
REQ-018 SHALL drive rom_en_o = push.
REQ-019 SHALL, on push, write {pc, rom_data_i} at the write pointer and set pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-020 SHALL, on pop, advance the read pointer.
REQ-021 SHALL, on push and pop in the same cycle, leave count unchanged; this is legal when full.
REQ-022 SHALL wrap the pointers modulo DEPTH.
REQ-023 SHALL drive inst_valid_o = (count != 0) && !jump_en_i.
REQ-024 SHALL drive inst_o and inst_addr_o from the FIFO head when count != 0, and 32'h0 otherwise.
REQ-025 SHALL, when jump_en_i = 1, discard all FIFO entries (count <= 0, pointers <= 0), set pc <= {jump_addr_i[31:2], 2'b00}, and perform no push and no pop that cycle.
REQ-026 SHALL fetch the jump target in the cycle after jump_en_i, and present it on inst_o one cycle after that.
REQ-027 SHALL have a fetch-to-present latency of one cycle: a word pushed in cycle N is presentable in cycle N+1.
REQ-028 SHALL make consecutive jump_en_i cycles keep the FIFO empty, with the last target taking effect.
REQ-029 SHALL ignore inst_ready_i while inst_valid_o = 0.
REQ-030 SHALL, when full with inst_ready_i = 0, hold pc and all FIFO contents stable with rom_en_o = 0.

Reset
REQ-031 SHALL, in any cycle with rst = 0, set pc <= RESET_PC, pointers <= 0 and count <= 0, overriding jump, push and pop.
REQ-032 SHALL hold rom_en_o = 0 while rst = 0.
REQ-033 SHALL force inst_valid_o = 0, inst_o = 32'h0 and inst_addr_o = 32'h0 from the first edge with rst = 0 onward.
REQ-034 SHALL, if reset asserts mid-operation, drop all in-flight entries with no partial state retained.
REQ-035 SHALL fetch RESET_PC in the first cycle with rst = 1, and assert inst_valid_o in the following cycle.

Verification
REQ-036 SHALL verify startup streaming: rst low 3 cycles then high, inst_ready_i = 1, ROM[i] = i -> inst_addr_o = 0, 4, 8, ... on consecutive cycles, with inst_o = 0, 1, 2, ... one per cycle, starting the second cycle after release.
REQ-037 SHALL verify backpressure: inst_ready_i = 0 for 10 cycles -> exactly DEPTH pushes, then rom_en_o = 0 and pc = 4*DEPTH stable; on inst_ready_i = 1, entries emerge in order with no gaps or duplicates.
REQ-038 SHALL verify redirect: during streaming, jump_en_i = 1 with jump_addr_i = 32'h0000_0067 -> inst_valid_o = 0 that cycle, rom_addr_o = 32'h64 next cycle, and the next accepted inst_addr_o = 32'h64 with no older entry ever accepted.
REQ-039 SHALL verify full with simultaneous pop: FIFO full, inst_ready_i = 1 -> push and pop each cycle, count stays DEPTH, and the address sequence is contiguous.
REQ-040 SHALL verify wrap: jump to 32'hFFFF_FFF8 -> inst_addr_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-041 SHALL verify mid-run reset: rst = 0 for one cycle with the FIFO half full -> inst_valid_o = 0 the next cycle, then the stream restarts at RESET_PC.
